// File: rtl/bp_fe_pkg.sv
// rtl/bp_fe_pkg.sv - shared types, widths and parcel helpers for the fetch realigner
package bp_fe_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } e_bp_inv_cfg;

    localparam int bp_fe_vaddr_width_gp = 39;
    localparam int bp_fe_instr_width_gp = 32;
    localparam int rvc_parcel_width_gp  = 16;

    typedef struct packed {
        logic                            v;
        logic [bp_fe_vaddr_width_gp-1:0] pc;
        logic [rvc_parcel_width_gp-1:0]  data;
    } bp_fe_parcel_s;

    function automatic int bp_fe_vaddr_width(input e_bp_inv_cfg cfg);
        case (cfg)
            e_bp_default_cfg: return bp_fe_vaddr_width_gp;
            default:          return bp_fe_vaddr_width_gp;
        endcase
    endfunction

    function automatic logic bp_fe_is_compressed(input logic [rvc_parcel_width_gp-1:0] parcel);
        return parcel[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/bp_fe_expander.sv
// rtl/bp_fe_expander.sv - RV32C parcel to 32-bit instruction expander
module bp_fe_expander
    import bp_fe_pkg::*;
(
    input  logic [rvc_parcel_width_gp-1:0]  parcel_i,
    output logic [bp_fe_instr_width_gp-1:0] instr_o,
    output logic                            v_o
);

    logic [15:0] c;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [31:0] instr;
    logic        v;

    assign c    = parcel_i;
    assign rd   = c[11:7];
    assign rs2  = c[6:2];
    assign rdp  = {2'b01, c[4:2]};
    assign rs1p = {2'b01, c[9:7]};

    // Decode quadrant/funct3 and rebuild the equivalent base encoding; v=0 for reserved/unsupported parcels
    always_comb begin
        instr = '0;
        v     = 1'b1;
        case (c[1:0])
            2'b00: case (c[15:13])
                3'b000: begin
                    instr = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, 7'b0010011};
                    v     = (c[12:5] != 8'd0);
                end
                3'b010: instr = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, 7'b0000011};
                3'b110: instr = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'b0100011};
                default: v = 1'b0;
            endcase
            2'b01: case (c[15:13])
                3'b000: instr = {{6{c[12]}}, c[12], c[6:2], rd, 3'b000, rd, 7'b0010011};
                3'b001: instr = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12], {8{c[12]}}, 5'd1, 7'b1101111};
                3'b010: instr = {{6{c[12]}}, c[12], c[6:2], 5'd0, 3'b000, rd, 7'b0010011};
                3'b011: begin
                    if (rd == 5'd2) begin
                        instr = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'd2, 3'b000, 5'd2, 7'b0010011};
                    end else begin
                        instr = {{15{c[12]}}, c[6:2], rd, 7'b0110111};
                    end
                    v = ({c[12], c[6:2]} != 6'd0) && (rd != 5'd0);
                end
                3'b100: case (c[11:10])
                    2'b00: begin
                        instr = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'b0010011};
                        v     = !c[12];
                    end
                    2'b01: begin
                        instr = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'b0010011};
                        v     = !c[12];
                    end
                    2'b10: instr = {{6{c[12]}}, c[12], c[6:2], rs1p, 3'b111, rs1p, 7'b0010011};
                    default: begin
                        v = !c[12];
                        case (c[6:5])
                            2'b00:   instr = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'b0110011};
                            2'b01:   instr = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'b0110011};
                            2'b10:   instr = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'b0110011};
                            default: instr = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'b0110011};
                        endcase
                    end
                endcase
                3'b101: instr = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12], {8{c[12]}}, 5'd0, 7'b1101111};
                3'b110: instr = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 3'b000, c[11:10], c[4:3], c[12], 7'b1100011};
                default: instr = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 3'b001, c[11:10], c[4:3], c[12], 7'b1100011};
            endcase
            2'b10: case (c[15:13])
                3'b000: begin
                    instr = {7'b0, c[6:2], rd, 3'b001, rd, 7'b0010011};
                    v     = !c[12];
                end
                3'b010: begin
                    instr = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'b0000011};
                    v     = (rd != 5'd0);
                end
                3'b100: begin
                    if (!c[12]) begin
                        if (rs2 == 5'd0) begin
                            instr = {12'b0, rd, 3'b000, 5'd0, 7'b1100111};
                            v     = (rd != 5'd0);
                        end else begin
                            instr = {7'b0, rs2, 5'd0, 3'b000, rd, 7'b0110011};
                        end
                    end else if (rs2 == 5'd0) begin
                        instr = (rd == 5'd0) ? 32'h0010_0073 : {12'b0, rd, 3'b000, 5'd1, 7'b1100111};
                    end else begin
                        instr = {7'b0, rs2, rd, 3'b000, rd, 7'b0110011};
                    end
                end
                3'b110: instr = {4'b0, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, 7'b0100011};
                default: v = 1'b0;
            endcase
            default: v = 1'b0;
        endcase
    end

    assign v_o     = v;
    assign instr_o = v ? instr : '0;

endmodule

// File: rtl/bp_fe_instr_realigner.sv
// rtl/bp_fe_instr_realigner.sv - fetch-word to instruction realigner (optional: BP_FE_REALIGN_ILLEGAL_EN)
module bp_fe_instr_realigner
    import bp_fe_pkg::*;
#(
    parameter e_bp_inv_cfg cfg_p = e_bp_default_cfg,
    localparam int vaddr_width_p = bp_fe_vaddr_width(cfg_p),
    localparam int instr_width_p = bp_fe_instr_width_gp
)
(
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     redirect_v_i,
    input  logic [vaddr_width_p-1:0] redirect_pc_i,
    input  logic                     fetch_v_i,
    input  logic [31:0]              fetch_data_i,
    input  logic [vaddr_width_p-1:0] fetch_pc_i,
    output logic                     fetch_yumi_o,
    output logic                     instr_v_o,
    output logic [instr_width_p-1:0] instr_o,
    output logic [vaddr_width_p-1:0] instr_pc_o,
    output logic                     instr_compressed_o,
    output logic                     instr_illegal_o,
    input  logic                     instr_ready_i
);

    bp_fe_parcel_s parcel_q, parcel_d;
    logic          skip_q, skip_d;

    logic [15:0]              exp_parcel;
    logic [instr_width_p-1:0] exp_instr, c_instr;
    logic                     exp_v, c_illegal;
    logic                     held_c, low_c;
    logic                     instr_v, yumi, comp, illegal;
    logic [instr_width_p-1:0] instr;
    logic [vaddr_width_p-1:0] instr_pc, upper_pc;

    // Only the halfword select of the restart PC matters here; the fetch unit owns the rest
    logic unused_redirect_pc;
    assign unused_redirect_pc = ^{redirect_pc_i[vaddr_width_p-1:2], redirect_pc_i[0]};

    assign held_c     = bp_fe_is_compressed(parcel_q.data);
    assign low_c      = bp_fe_is_compressed(fetch_data_i[15:0]);
    assign exp_parcel = parcel_q.v ? parcel_q.data : fetch_data_i[15:0];
    assign upper_pc   = fetch_pc_i + vaddr_width_p'(2);

    bp_fe_expander expander (
        .parcel_i (exp_parcel),
        .instr_o  (exp_instr),
        .v_o      (exp_v)
    );

`ifdef BP_FE_REALIGN_ILLEGAL_EN
    assign c_instr   = exp_v ? exp_instr : {16'b0, exp_parcel};
    assign c_illegal = !exp_v;
`else
    logic unused_exp_v;
    assign unused_exp_v = exp_v;
    assign c_instr      = exp_instr;
    assign c_illegal    = 1'b0;
`endif

    // Pick the issuing parcel source and the next held-parcel state; redirect beats everything
    always_comb begin
        parcel_d = parcel_q;
        skip_d   = skip_q;
        instr_v  = 1'b0;
        yumi     = 1'b0;
        instr    = '0;
        instr_pc = '0;
        comp     = 1'b0;
        illegal  = 1'b0;
        if (redirect_v_i) begin
            parcel_d.v = 1'b0;
            skip_d     = redirect_pc_i[1];
        end else if (parcel_q.v && held_c) begin
            instr_v  = 1'b1;
            instr    = c_instr;
            instr_pc = parcel_q.pc;
            comp     = 1'b1;
            illegal  = c_illegal;
            if (instr_ready_i) parcel_d.v = 1'b0;
        end else if (parcel_q.v) begin
            instr_v  = fetch_v_i;
            instr    = {fetch_data_i[15:0], parcel_q.data};
            instr_pc = parcel_q.pc;
            if (fetch_v_i && instr_ready_i) begin
                yumi     = 1'b1;
                parcel_d = '{v: 1'b1, pc: upper_pc, data: fetch_data_i[31:16]};
            end
        end else if (fetch_v_i && skip_q) begin
            yumi     = 1'b1;
            parcel_d = '{v: 1'b1, pc: upper_pc, data: fetch_data_i[31:16]};
            skip_d   = 1'b0;
        end else if (fetch_v_i && low_c) begin
            instr_v  = 1'b1;
            instr    = c_instr;
            instr_pc = fetch_pc_i;
            comp     = 1'b1;
            illegal  = c_illegal;
            if (instr_ready_i) begin
                yumi     = 1'b1;
                parcel_d = '{v: 1'b1, pc: upper_pc, data: fetch_data_i[31:16]};
            end
        end else if (fetch_v_i) begin
            instr_v  = 1'b1;
            instr    = fetch_data_i;
            instr_pc = fetch_pc_i;
            yumi     = instr_ready_i;
        end
    end

    // Held parcel and post-redirect skip flag; async reset drops any half-joined instruction
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            parcel_q <= '0;
            skip_q   <= 1'b0;
        end else begin
            parcel_q <= parcel_d;
            skip_q   <= skip_d;
        end
    end

    assign instr_v_o          = reset_n_i & instr_v;
    assign fetch_yumi_o       = reset_n_i & yumi;
    assign instr_o            = reset_n_i ? instr : '0;
    assign instr_pc_o         = reset_n_i ? instr_pc : '0;
    assign instr_compressed_o = reset_n_i & comp;
    assign instr_illegal_o    = reset_n_i & illegal;

endmodule
